// File: rtl/gpr_dump_port.sv
// Debug-path register-file access initiator: dumps all eight GPRs over a valid/ready stream
// and performs single 8/16-bit GPR writes while the core grants register-file access.
module gpr_dump_port (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        dump_start_i,
  input  logic        wr_req_i,
  input  logic [2:0]  wr_sel_i,
  input  logic [15:0] wr_val_i,
  input  logic        wr_is_8_bit_i,
  output logic        wr_ack_o,
  output logic        busy_o,
  output logic        rf_req_o,
  input  logic        rf_grant_i,
  output logic [2:0]  rf_rd_sel_o,
  input  logic [15:0] rf_rd_val_i,
  output logic [2:0]  rf_wr_sel_o,
  output logic [15:0] rf_wr_val_o,
  output logic        rf_wr_en_o,
  output logic        rf_is_8_bit_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [15:0] out_data_o,
  output logic [2:0]  out_idx_o,
  output logic        out_last_o
);

  typedef enum logic [2:0] {StIdle, StArb, StWrite, StIssue, StCapture, StSend} state_e;

  state_e      state_q, state_d;
  logic        kind_wr_q, kind_wr_d;
  logic [2:0]  idx_q, idx_d;
  logic        pend_q, pend_d;
  logic [15:0] data_q, data_d;
  logic        pend_set;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      kind_wr_q <= 1'b0;
      idx_q     <= 3'd0;
      pend_q    <= 1'b0;
      data_q    <= 16'd0;
    end else begin
      state_q   <= state_d;
      kind_wr_q <= kind_wr_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      data_q    <= data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    kind_wr_d = kind_wr_q;
    idx_d     = idx_q;
    data_d    = data_q;

    // A dump request is remembered only if it cannot start now and no dump is running.
    pend_set = dump_start_i && ((state_q == StIdle) ? wr_req_i : kind_wr_q);
    pend_d   = pend_q | pend_set;

    wr_ack_o      = 1'b0;
    rf_rd_sel_o   = 3'd0;
    rf_wr_sel_o   = 3'd0;
    rf_wr_val_o   = 16'd0;
    rf_wr_en_o    = 1'b0;
    rf_is_8_bit_o = 1'b0;
    out_valid_o   = 1'b0;
    out_last_o    = 1'b0;
    rf_req_o      = (state_q != StIdle);
    busy_o        = (state_q != StIdle);
    out_idx_o     = idx_q;
    out_data_o    = data_q;

    unique case (state_q)
      StIdle: begin
        if (wr_req_i) begin
          state_d   = StArb;
          kind_wr_d = 1'b1;
        end else if (dump_start_i || pend_q) begin
          state_d   = StArb;
          kind_wr_d = 1'b0;
          idx_d     = 3'd0;
          pend_d    = 1'b0;
        end
      end
      StArb: begin
        if (rf_grant_i) state_d = kind_wr_q ? StWrite : StIssue;
      end
      StWrite: begin
        wr_ack_o      = 1'b1;
        rf_wr_en_o    = 1'b1;
        rf_wr_sel_o   = wr_sel_i;
        rf_wr_val_o   = wr_val_i;
        rf_is_8_bit_o = wr_is_8_bit_i;
        if (pend_d) begin
          state_d   = StArb;
          kind_wr_d = 1'b0;
          idx_d     = 3'd0;
          pend_d    = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      StIssue: begin
        rf_rd_sel_o = idx_q;
        if (rf_grant_i) state_d = StCapture;
      end
      StCapture: begin
        // Read data is registered in the core, so it is valid here even if grant dropped.
        data_d  = rf_rd_val_i;
        state_d = StSend;
      end
      StSend: begin
        out_valid_o = 1'b1;
        out_last_o  = (idx_q == 3'd7);
        if (out_ready_i) begin
          if (idx_q == 3'd7) begin
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = StIssue;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_gpr_dump_port.sv
// Self-checking bench for gpr_dump_port: register-file and stream models, vector table of writes,
// directed dump corner cases and randomized write/dump traffic against an array reference model.
module tb_gpr_dump_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dump_start, wr_req, wr_is_8_bit;
  logic [2:0]  wr_sel;
  logic [15:0] wr_val;
  logic        wr_ack, busy, rf_req, rf_wr_en, rf_is_8_bit, out_valid, out_last;
  logic [2:0]  rf_rd_sel, rf_wr_sel, out_idx;
  logic [15:0] rf_wr_val, out_data, rd_q;
  logic        grant_m, ready_m, rnd_grant, rnd_ready, grant_rand_en, ready_rand_en, load_en;
  logic        rf_grant, out_ready;

  logic [15:0] rf     [8];
  logic [15:0] exp_rf [8];
  logic [19:0] got_q  [$];
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  assign rf_grant  = grant_rand_en ? rnd_grant : grant_m;
  assign out_ready = ready_rand_en ? rnd_ready : ready_m;

  gpr_dump_port dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .dump_start_i (dump_start),
    .wr_req_i     (wr_req),
    .wr_sel_i     (wr_sel),
    .wr_val_i     (wr_val),
    .wr_is_8_bit_i(wr_is_8_bit),
    .wr_ack_o     (wr_ack),
    .busy_o       (busy),
    .rf_req_o     (rf_req),
    .rf_grant_i   (rf_grant),
    .rf_rd_sel_o  (rf_rd_sel),
    .rf_rd_val_i  (rd_q),
    .rf_wr_sel_o  (rf_wr_sel),
    .rf_wr_val_o  (rf_wr_val),
    .rf_wr_en_o   (rf_wr_en),
    .rf_is_8_bit_o(rf_is_8_bit),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .out_idx_o    (out_idx),
    .out_last_o   (out_last)
  );

  // 8-bit selects 0..3 hit the low byte of regs 0..3, selects 4..7 the high byte.
  function automatic logic [2:0] wr_reg(input logic [2:0] sel, input logic is8);
    return is8 ? {1'b0, sel[1:0]} : sel;
  endfunction

  function automatic logic [15:0] wr_merge(input logic [15:0] old, input logic [2:0] sel,
                                           input logic [15:0] val, input logic is8);
    if (!is8) return val;
    if (sel[2]) return {val[7:0], old[7:0]};
    return {old[15:8], val[7:0]};
  endfunction

  // Core register file: registered read, one write port.
  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 8; i++) rf[i] <= 16'h1100 + 16'(i);
    end else begin
      rd_q <= rf[rf_rd_sel];
      if (rf_wr_en)
        rf[wr_reg(rf_wr_sel, rf_is_8_bit)] <=
            wr_merge(rf[wr_reg(rf_wr_sel, rf_is_8_bit)], rf_wr_sel, rf_wr_val, rf_is_8_bit);
    end
  end

  always @(posedge clk) begin
    #1;
    rnd_grant = ($urandom_range(0, 3) != 0);
    rnd_ready = ($urandom_range(0, 1) != 0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: got timeout, expected completion", name);
  endtask

  // Stream monitor: collects beats, checks stall stability and write-enable shape.
  logic [19:0] prev_out;
  bit          stall, prev_wr_en;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall      = 1'b0;
      prev_wr_en = 1'b0;
    end else begin
      if (stall) chk("out_stable", 64'({out_last, out_idx, out_data}), 64'(prev_out));
      stall    = out_valid && !out_ready;
      prev_out = {out_last, out_idx, out_data};
      if (out_valid && out_ready) got_q.push_back({out_last, out_idx, out_data});
      if (rf_wr_en || wr_ack) chk("wr_en_with_ack", 64'(rf_wr_en), 64'(wr_ack));
      if (rf_wr_en && prev_wr_en) chk("wr_en_single", 64'(prev_wr_en), 64'(0));
      prev_wr_en = rf_wr_en;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_dump(input string name);
    logic [19:0] b;
    chk({name, "_count"}, 64'(got_q.size()), 64'(8));
    for (int i = 0; i < 8; i++) begin
      if (i < got_q.size()) begin
        b = got_q[i];
        chk({name, "_data"}, 64'(b[15:0]), 64'(exp_rf[i]));
        chk({name, "_idx"}, 64'(b[18:16]), 64'(i));
        chk({name, "_last"}, 64'(b[19]), 64'(i == 7));
      end
    end
    got_q.delete();
  endtask

  task automatic do_dump(input int budget, output logic first_req, output int cnt);
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    first_req  = rf_req;
    cnt        = 1;
    while (busy && cnt < budget) begin
      step();
      cnt++;
    end
    if (busy) fail_now("dump_timeout");
  endtask

  task automatic do_write(input logic [2:0] sel, input logic [15:0] val, input logic is8,
                          input int budget, output int lat, output logic [20:0] seen);
    wr_sel      = sel;
    wr_val      = val;
    wr_is_8_bit = is8;
    wr_req      = 1'b1;
    lat         = 0;
    do begin
      step();
      lat++;
    end while (!wr_ack && lat < budget);
    if (!wr_ack) fail_now("write_timeout");
    seen   = {rf_wr_en, rf_is_8_bit, rf_wr_sel, rf_wr_val};
    wr_req = 1'b0;
    exp_rf[wr_reg(sel, is8)] = wr_merge(exp_rf[wr_reg(sel, is8)], sel, val, is8);
    step();
  endtask

  function automatic logic [47:0] all_outs();
    return {wr_ack, busy, rf_req, rf_rd_sel, rf_wr_sel, rf_wr_val, rf_wr_en, rf_is_8_bit,
            out_valid, out_data, out_idx, out_last};
  endfunction

  typedef struct {
    logic [2:0]  sel;
    logic [15:0] val;
    logic        is8;
    int          reg_i;
    logic [15:0] reg_val;
  } wvec_t;

  initial begin
    wvec_t       tbl [5];
    logic        fr;
    int          cnt, lat, gdrop;
    bit          dropped;
    logic [20:0] seen;
    logic [19:0] first;
    logic [2:0]  rs;
    logic [15:0] rv;
    logic        r8;

    // Register contents start at 0x1100+i; reg_val is the whole register after the write.
    tbl[0] = '{sel: 3'd7, val: 16'h00AB, is8: 1'b1, reg_i: 3, reg_val: 16'hAB03};
    tbl[1] = '{sel: 3'd2, val: 16'h1234, is8: 1'b1, reg_i: 2, reg_val: 16'h1134};
    tbl[2] = '{sel: 3'd5, val: 16'hBEEF, is8: 1'b0, reg_i: 5, reg_val: 16'hBEEF};
    tbl[3] = '{sel: 3'd4, val: 16'hFF77, is8: 1'b1, reg_i: 0, reg_val: 16'h7700};
    tbl[4] = '{sel: 3'd6, val: 16'h0000, is8: 1'b0, reg_i: 6, reg_val: 16'h0000};

    rst_n = 1'b0; dump_start = 1'b0; wr_req = 1'b0; wr_sel = 3'd0; wr_val = 16'd0;
    wr_is_8_bit = 1'b0; grant_m = 1'b1; ready_m = 1'b1; grant_rand_en = 1'b0;
    ready_rand_en = 1'b0; load_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'(all_outs()), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    load_en = 1'b0;
    for (int i = 0; i < 8; i++) exp_rf[i] = 16'h1100 + 16'(i);
    rst_n = 1'b1;
    step();

    // Plain dump, grant and ready held high.
    do_dump(100, fr, cnt);
    chk("dump_first_req", 64'(fr), 64'(1));
    chk("dump_cycles", 64'(cnt), 64'(26));
    check_dump("dump_plain");

    // Table of single writes with grant high.
    foreach (tbl[k]) begin
      do_write(tbl[k].sel, tbl[k].val, tbl[k].is8, 20, lat, seen);
      chk("tbl_latency", 64'(lat), 64'(2));
      chk("tbl_rf_wr", 64'(seen), 64'({1'b1, tbl[k].is8, tbl[k].sel, tbl[k].val}));
      chk("tbl_reg", 64'(rf[tbl[k].reg_i]), 64'(tbl[k].reg_val));
    end
    do_dump(100, fr, cnt);
    check_dump("dump_after_writes");

    // dump_start together with wr_req: write first, then the dump.
    wr_sel = 3'd0; wr_val = 16'h5A5A; wr_is_8_bit = 1'b0;
    dump_start = 1'b1; wr_req = 1'b1;
    step();
    dump_start = 1'b0;
    lat = 1;
    while (!wr_ack && lat < 20) begin
      step();
      lat++;
    end
    if (!wr_ack) fail_now("same_cycle_write_timeout");
    chk("same_cycle_latency", 64'(lat), 64'(2));
    wr_req = 1'b0;
    exp_rf[0] = 16'h5A5A;
    cnt = 0;
    while (busy && cnt < 100) begin
      step();
      cnt++;
    end
    if (busy) fail_now("same_cycle_dump_timeout");
    first = (got_q.size() != 0) ? got_q[0] : 20'd0;
    chk("same_cycle_first_beat", 64'(first), 64'({1'b0, 3'd0, 16'h5A5A}));
    check_dump("dump_same_cycle");

    // Random ready, grant dropped for 3 cycles while idx 4 is being issued.
    ready_rand_en = 1'b1;
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    dropped = 1'b0; gdrop = 0; cnt = 1;
    while (busy && cnt < 600) begin
      if (gdrop != 0) begin
        chk("grant_drop_req_held", 64'(rf_req), 64'(1));
        gdrop--;
        if (gdrop == 0) grant_m = 1'b1;
      end else if (!dropped && rf_rd_sel == 3'd4) begin
        grant_m = 1'b0;
        dropped = 1'b1;
        gdrop   = 3;
      end
      step();
      cnt++;
    end
    if (busy) fail_now("grant_drop_timeout");
    chk("grant_drop_seen", 64'(dropped), 64'(1));
    grant_m = 1'b1;
    ready_rand_en = 1'b0;
    check_dump("dump_grant_drop");

    // Randomized writes and dumps with random grant and ready.
    grant_rand_en = 1'b1;
    ready_rand_en = 1'b1;
    for (int op = 0; op < 14; op++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_dump(800, fr, cnt);
        check_dump("dump_random");
      end else begin
        rs = 3'($urandom_range(0, 7));
        rv = 16'($urandom());
        r8 = 1'($urandom_range(0, 1));
        do_write(rs, rv, r8, 200, lat, seen);
        chk("rand_rf_wr", 64'(seen), 64'({1'b1, r8, rs, rv}));
      end
    end
    do_dump(800, fr, cnt);
    check_dump("dump_random_final");
    grant_rand_en = 1'b0;
    ready_rand_en = 1'b0;

    // Reset while SEND is stalled at idx 3.
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    cnt = 0;
    while (!(out_valid && out_idx == 3'd3) && cnt < 100) begin
      step();
      cnt++;
    end
    ready_m = 1'b0;
    if (!(out_valid && out_idx == 3'd3)) fail_now("reach_idx3_timeout");
    step();
    rst_n = 1'b0;
    #1;
    chk("reset_mid_outputs", 64'(all_outs()), 64'(0));
    got_q.delete();
    step();
    step();
    rst_n   = 1'b1;
    ready_m = 1'b1;
    repeat (10) step();
    chk("post_reset_idle", 64'(busy), 64'(0));
    chk("post_reset_no_beats", 64'(got_q.size()), 64'(0));
    do_dump(100, fr, cnt);
    chk("post_reset_cycles", 64'(cnt), 64'(26));
    check_dump("dump_post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
